// File: rtl/cv32e40p_tmr_pkg.sv
// Shared types for the TMR fault manager: FSM states, replica indices and
// replica mask helpers.
package cv32e40p_tmr_pkg;

  localparam int NUM_REP = 3;
  localparam int REP_A   = 0;
  localparam int REP_B   = 1;
  localparam int REP_C   = 2;

  typedef logic [NUM_REP-1:0] rep_mask_t;

  typedef enum logic [1:0] {
    FM_IDLE,
    FM_REQ,
    FM_COOLDOWN,
    FM_DEGRADED
  } tmr_fm_state_e;

  // Fixed priority a > b > c; returns a one-hot (or zero) mask.
  function automatic rep_mask_t prio_pick(rep_mask_t m);
    rep_mask_t r;
    r = '0;
    if (m[REP_A])      r[REP_A] = 1'b1;
    else if (m[REP_B]) r[REP_B] = 1'b1;
    else if (m[REP_C]) r[REP_C] = 1'b1;
    return r;
  endfunction

  function automatic logic [1:0] popcnt3(rep_mask_t m);
    return {1'b0, m[REP_A]} + {1'b0, m[REP_B]} + {1'b0, m[REP_C]};
  endfunction

endpackage

// File: rtl/cv32e40p_tmr_sat_counter.sv
// Per-replica up/down saturating mismatch counter; inc and dec together hold.
module cv32e40p_tmr_sat_counter
  import cv32e40p_tmr_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_nxt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_comb begin
    cnt_nxt = cnt;
    if (inc && !dec) begin
      if (cnt != CNT_MAX) cnt_nxt = cnt + 1'b1;
    end else if (dec && !inc) begin
      if (cnt != '0) cnt_nxt = cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) cnt <= '0;
    else              cnt <= cnt_nxt;
  end

endmodule

// File: rtl/cv32e40p_tmr_fault_manager.sv
// TMR fault manager: counts per-replica voter mismatches with leaky decay,
// drives resync req/ack, retires faulty replicas and raises halt when TMR is
// lost. Optional event statistics under `CV32E40P_TMR_FM_STATS_EN`.
module cv32e40p_tmr_fault_manager
  import cv32e40p_tmr_pkg::*;
#(
  parameter int THRESHOLD = 4,
  parameter int CNT_W     = 8,
  parameter int WINDOW    = 256,
  parameter int COOLDOWN  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_i,
  input  logic               valid_i,
  input  logic               err_a_i,
  input  logic               err_b_i,
  input  logic               err_c_i,
  input  logic               resync_ack_i,
  output logic               resync_req_o,
  output rep_mask_t          resync_target_o,
  output rep_mask_t          faulty_o,
  output logic               halt_req_o,
  output logic               all_mismatch_o,
  output logic [3*CNT_W-1:0] err_cnt_o,
  output logic [31:0]        total_events_o
);

  localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int CD_W  = $clog2(COOLDOWN + 1);
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'((COOLDOWN > 0) ? COOLDOWN - 1 : 0);

  tmr_fm_state_e state;
  rep_mask_t     pending, target;
  rep_mask_t     flags, cd_mask, ev_mask, cnt_inc, cnt_dec;
  rep_mask_t     new_faulty, faulty_nxt, set_pend, pend_all, pick;
  logic          single_ev, triple_ev, lose_tmr, tick;
  logic [WIN_W-1:0] win_cnt;
  logic [CD_W-1:0]  cd_cnt;
  logic [NUM_REP-1:0][CNT_W-1:0] cnt, cnt_nxt;

  // Retired replicas and the replica just resynced are blind to the voter.
  assign flags     = {err_c_i, err_b_i, err_a_i};
  assign cd_mask   = (state == FM_COOLDOWN) ? target : '0;
  assign ev_mask   = valid_i ? (flags & ~faulty_o & ~cd_mask) : '0;
  assign single_ev = (popcnt3(ev_mask) == 2'd1);
  assign triple_ev = (popcnt3(ev_mask) >= 2'd2);
  assign cnt_inc   = single_ev ? ev_mask : '0;
  assign tick      = (win_cnt == WIN_W'(WINDOW - 1));

  for (genvar r = 0; r < NUM_REP; r++) begin : g_rep
    assign cnt_dec[r] = tick & ~faulty_o[r] & (|cnt[r]);

    cv32e40p_tmr_sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .clear   (clear_i),
      .inc     (cnt_inc[r]),
      .dec     (cnt_dec[r]),
      .cnt     (cnt[r]),
      .cnt_nxt (cnt_nxt[r])
    );

    assign new_faulty[r] = cnt_inc[r] & (32'(cnt_nxt[r]) >= 32'(THRESHOLD));
  end

  assign err_cnt_o  = cnt;
  assign faulty_nxt = faulty_o | new_faulty;
  assign set_pend   = cnt_inc & ~new_faulty;
  // A replica that was just retired must never be resynced later.
  assign pend_all   = (pending | set_pend) & ~faulty_nxt;
  assign pick       = prio_pick(pend_all);
  assign lose_tmr   = triple_ev || (popcnt3(faulty_nxt) >= 2'd2);

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      state           <= FM_IDLE;
      pending         <= '0;
      target          <= '0;
      resync_req_o    <= 1'b0;
      resync_target_o <= '0;
      faulty_o        <= '0;
      halt_req_o      <= 1'b0;
      all_mismatch_o  <= 1'b0;
      cd_cnt          <= '0;
      win_cnt         <= '0;
    end else begin
      win_cnt  <= tick ? '0 : win_cnt + 1'b1;
      faulty_o <= faulty_nxt;
      pending  <= pend_all;
      if (triple_ev) all_mismatch_o <= 1'b1;
      if (lose_tmr)  halt_req_o     <= 1'b1;

      if (lose_tmr) begin
        state           <= FM_DEGRADED;
        resync_req_o    <= 1'b0;
        resync_target_o <= '0;
        target          <= '0;
      end else begin
        case (state)
          FM_IDLE: begin
            if (|pend_all) begin
              state           <= FM_REQ;
              target          <= pick;
              resync_target_o <= pick;
              resync_req_o    <= 1'b1;
              pending         <= pend_all & ~pick;
            end
          end
          FM_REQ: begin
            if (resync_ack_i) begin
              state           <= FM_COOLDOWN;
              resync_req_o    <= 1'b0;
              resync_target_o <= '0;
              cd_cnt          <= CD_LOAD;
            end
          end
          FM_COOLDOWN: begin
            if (cd_cnt == '0) begin
              state  <= FM_IDLE;
              target <= '0;
            end else begin
              cd_cnt <= cd_cnt - 1'b1;
            end
          end
          FM_DEGRADED: begin
            resync_req_o    <= 1'b0;
            resync_target_o <= '0;
          end
          default: state <= FM_IDLE;
        endcase
      end
    end
  end

`ifdef CV32E40P_TMR_FM_STATS_EN
  logic [31:0] total_q;
  logic        any_ev;

  // Raw flags on purpose: masked and cooldown events are still recorded.
  assign any_ev = valid_i && (|flags);

  always_ff @(posedge clk) begin
    if (rst || clear_i)                   total_q <= '0;
    else if (any_ev && (total_q != '1))   total_q <= total_q + 1'b1;
  end

  assign total_events_o = total_q;
`else
  assign total_events_o = '0;
`endif

endmodule

// File: tb/tb_cv32e40p_tmr_fault_manager.sv
// Directed, table-driven bench for cv32e40p_tmr_fault_manager
// (THRESHOLD=4, CNT_W=8, WINDOW=16, COOLDOWN=8).
module tb_cv32e40p_tmr_fault_manager;

  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear_i = 1'b0, valid_i = 1'b0, resync_ack_i = 1'b0;
  logic err_a_i = 1'b0, err_b_i = 1'b0, err_c_i = 1'b0;
  logic resync_req_o, halt_req_o, all_mismatch_o;
  logic [2:0] resync_target_o, faulty_o;
  logic [3*CNT_W-1:0] err_cnt_o;
  logic [31:0] total_events_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cv32e40p_tmr_fault_manager #(
    .THRESHOLD(4), .CNT_W(CNT_W), .WINDOW(16), .COOLDOWN(8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .clear_i         (clear_i),
    .valid_i         (valid_i),
    .err_a_i         (err_a_i),
    .err_b_i         (err_b_i),
    .err_c_i         (err_c_i),
    .resync_ack_i    (resync_ack_i),
    .resync_req_o    (resync_req_o),
    .resync_target_o (resync_target_o),
    .faulty_o        (faulty_o),
    .halt_req_o      (halt_req_o),
    .all_mismatch_o  (all_mismatch_o),
    .err_cnt_o       (err_cnt_o),
    .total_events_o  (total_events_o)
  );

  // {req, target, faulty, halt, all_mismatch, cnt{c,b,a}}
  logic [32:0] obs;
  assign obs = {resync_req_o, resync_target_o, faulty_o, halt_req_o, all_mismatch_o, err_cnt_o};

  typedef struct {
    string       name;
    logic        cl;
    logic        v;
    logic [2:0]  f;   // {c,b,a}
    logic        k;
    logic [32:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(string n, logic cl, logic v, logic [2:0] f, logic k,
                              logic req, logic [2:0] tgt, logic [2:0] flt,
                              logic halt, logic amm, logic [23:0] cnt);
    vec_t t;
    t.name = n; t.cl = cl; t.v = v; t.f = f; t.k = k;
    t.exp  = {req, tgt, flt, halt, amm, cnt};
    tbl.push_back(t);
  endfunction

  // Inputs change 1 time unit after an edge; outputs are sampled 1 unit after the next.
  task automatic drive(input logic cl, input logic v, input logic [2:0] f, input logic k);
    clear_i = cl; valid_i = v; {err_c_i, err_b_i, err_a_i} = f; resync_ack_i = k;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string n, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  initial begin
    // reset release + single event on b, cooldown length, tick+inc hold
    add("idle0",        0,0,3'b000,0, 0,3'b000,3'b000,0,0,24'h000000);
    add("ack_in_idle",  0,0,3'b000,1, 0,3'b000,3'b000,0,0,24'h000000);
    add("valid_noflag", 0,1,3'b000,0, 0,3'b000,3'b000,0,0,24'h000000);
    add("ev_b",         0,1,3'b010,0, 1,3'b010,3'b000,0,0,24'h000100);
    add("req_hold0",    0,0,3'b000,0, 1,3'b010,3'b000,0,0,24'h000100);
    add("req_hold1",    0,0,3'b000,0, 1,3'b010,3'b000,0,0,24'h000100);
    add("ack_b",        0,0,3'b000,1, 0,3'b000,3'b000,0,0,24'h000100);
    add("cd_mask_b",    0,1,3'b010,0, 0,3'b000,3'b000,0,0,24'h000100);
    for (int i = 0; i < 6; i++)
      add("cd_idle",    0,0,3'b000,0, 0,3'b000,3'b000,0,0,24'h000100);
    add("cd_last_mask", 0,1,3'b010,0, 0,3'b000,3'b000,0,0,24'h000100);
    add("idle_b_tick",  0,1,3'b010,0, 1,3'b010,3'b000,0,0,24'h000100);
    add("ack_b2",       0,0,3'b000,1, 0,3'b000,3'b000,0,0,24'h000100);
    // triple mismatch / two flags / clear
    add("clear0",       1,0,3'b000,0, 0,3'b000,3'b000,0,0,24'h000000);
    add("triple",       0,1,3'b111,0, 0,3'b000,3'b000,1,1,24'h000000);
    add("degr_hold",    0,0,3'b000,0, 0,3'b000,3'b000,1,1,24'h000000);
    add("degr_count",   0,1,3'b001,0, 0,3'b000,3'b000,1,1,24'h000001);
    add("degr_ack",     0,0,3'b000,1, 0,3'b000,3'b000,1,1,24'h000001);
    add("clear1",       1,0,3'b000,0, 0,3'b000,3'b000,0,0,24'h000000);
    add("two_flags",    0,1,3'b011,0, 0,3'b000,3'b000,1,1,24'h000000);
    add("clear2",       1,0,3'b000,0, 0,3'b000,3'b000,0,0,24'h000000);
    // replica a reaches threshold, request still completes, no later resync
    add("a1",           0,1,3'b001,0, 1,3'b001,3'b000,0,0,24'h000001);
    add("a2",           0,1,3'b001,0, 1,3'b001,3'b000,0,0,24'h000002);
    add("a3",           0,1,3'b001,0, 1,3'b001,3'b000,0,0,24'h000003);
    add("a4_faulty",    0,1,3'b001,0, 1,3'b001,3'b001,0,0,24'h000004);
    add("a5_masked",    0,1,3'b001,0, 1,3'b001,3'b001,0,0,24'h000004);
    add("ack_a",        0,0,3'b000,1, 0,3'b000,3'b001,0,0,24'h000004);
    for (int i = 0; i < 9; i++)
      add("a_no_resync",0,0,3'b000,0, 0,3'b000,3'b001,0,0,24'h000004);
    add("tick_faulty",  0,0,3'b000,0, 0,3'b000,3'b001,0,0,24'h000004);
    // second replica retired -> halt, later ack ignored, counting continues
    add("c1",           0,1,3'b100,0, 1,3'b100,3'b001,0,0,24'h010004);
    add("c2",           0,1,3'b100,0, 1,3'b100,3'b001,0,0,24'h020004);
    add("c3",           0,1,3'b100,0, 1,3'b100,3'b001,0,0,24'h030004);
    add("c4_halt",      0,1,3'b100,0, 0,3'b000,3'b101,1,0,24'h040004);
    add("ack_degr",     0,0,3'b000,1, 0,3'b000,3'b101,1,0,24'h040004);
    add("degr_b",       0,1,3'b010,0, 0,3'b000,3'b101,1,0,24'h040104);
    // event on c during b's cooldown
    add("clear3",       1,0,3'b000,0, 0,3'b000,3'b000,0,0,24'h000000);
    add("b_ev",         0,1,3'b010,0, 1,3'b010,3'b000,0,0,24'h000100);
    add("ack_b3",       0,0,3'b000,1, 0,3'b000,3'b000,0,0,24'h000100);
    add("c_in_cd",      0,1,3'b100,0, 0,3'b000,3'b000,0,0,24'h010100);
    for (int i = 0; i < 7; i++)
      add("cd_wait",    0,0,3'b000,0, 0,3'b000,3'b000,0,0,24'h010100);
    add("c_req",        0,0,3'b000,0, 1,3'b100,3'b000,0,0,24'h010100);
    add("ack_c",        0,0,3'b000,1, 0,3'b000,3'b000,0,0,24'h010100);

    // reset held two cycles with flags toggling
    rst = 1'b1;
    drive(0, 1, 3'b111, 1);
    check("rst_c0", obs, 33'h0);
    drive(0, 1, 3'b010, 0);
    check("rst_c1", obs, 33'h0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].cl, tbl[i].v, tbl[i].f, tbl[i].k);
      check(tbl[i].name, obs, tbl[i].exp);
    end

    // leaky decay: cnt_c=2 then idle cycles; ticks land at cycles 16 and 32 after clear
    drive(1, 0, 3'b000, 0);
    drive(0, 1, 3'b100, 0);
    drive(0, 1, 3'b100, 0);
    drive(0, 0, 3'b000, 1);
    check("decay_start", 33'(err_cnt_o[23:16]), 33'd2);
    for (int k = 4; k <= 35; k++) begin
      drive(0, 0, 3'b000, 0);
      if (k == 15) check("decay_pre_tick", 33'(err_cnt_o[23:16]), 33'd2);
      if (k == 16) check("decay_tick1",    33'(err_cnt_o[23:16]), 33'd1);
      if (k == 35) check("decay_end",      33'(err_cnt_o[23:16]), 33'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
